// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// req/ack handshake, holds it for the controller and advances on retire.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ack,
   input  logic             retire,
   input  logic             pcsrc,
   output logic [31:0]      instr,
   output logic [5:0]       op,
   output logic [5:0]       funct,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

   state_t           state, state_nxt;
   logic [7:0]       wait_cnt, wait_cnt_nxt;
   logic [31:0]      pc_nxt, instr_nxt, br_off;
   logic             req_nxt, valid_nxt, err_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign op        = instr[31:26];
   assign funct     = instr[5:0];
   assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // The request is registered, so the first cycle out of reset (and the
   // cycle after timeout) carries req=0; an ack without a live request is ignored.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr;
      valid_nxt    = instr_valid;
      req_nxt      = imem_req;
      err_nxt      = fetch_err;
      cnt_nxt      = retired_cnt;
      wait_cnt_nxt = wait_cnt;
      case (state)
         FETCH: begin
            if (!imem_req) begin
               req_nxt = 1'b1;
            end else if (imem_ack) begin
               instr_nxt    = imem_rdata;
               valid_nxt    = 1'b1;
               req_nxt      = 1'b0;
               wait_cnt_nxt = 8'd0;
               state_nxt    = EXEC;
            end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               req_nxt   = 1'b0;
               state_nxt = HALT;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         EXEC: begin
            if (retire) begin
               valid_nxt = 1'b0;
               instr_nxt = 32'd0;
               cnt_nxt   = retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               pc_nxt    = pcsrc ? pc_plus4 + br_off : pc_plus4;
               req_nxt   = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: begin
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         fetch_err   <= 1'b0;
         retired_cnt <= '0;
         wait_cnt    <= 8'd0;
      end else begin
         pc          <= pc_nxt;
         instr       <= instr_nxt;
         instr_valid <= valid_nxt;
         imem_req    <= req_nxt;
         fetch_err   <= err_nxt;
         retired_cnt <= cnt_nxt;
         wait_cnt    <= wait_cnt_nxt;
      end
   end

endmodule
